// File: rtl/axi4_master_engine.sv
// AXI4 burst initiator: takes one command at a time and runs a single INCR
// write (AW/W/B) or read (AR/R) burst, streaming beats to/from the user port.
module axi4_master_engine #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_write,
   input  logic [ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [7:0]              cmd_len,
   input  logic [DATA_WIDTH-1:0]   wr_data,
   input  logic                    wr_valid,
   output logic                    wr_ready,
   output logic [DATA_WIDTH-1:0]   rd_data,
   output logic                    rd_valid,
   input  logic                    rd_ready,
   output logic                    done_valid,
   output logic [1:0]              done_resp,
   output logic                    done_err,
   output logic [ADDR_WIDTH-1:0]   awaddr,
   output logic [7:0]              awlen,
   output logic [2:0]              awsize,
   output logic [1:0]              awburst,
   output logic                    awvalid,
   input  logic                    awready,
   output logic [DATA_WIDTH-1:0]   wdata,
   output logic [DATA_WIDTH/8-1:0] wstrb,
   output logic                    wlast,
   output logic                    wvalid,
   input  logic                    wready,
   input  logic [1:0]              bresp,
   input  logic                    bvalid,
   output logic                    bready,
   output logic [ADDR_WIDTH-1:0]   araddr,
   output logic [7:0]              arlen,
   output logic [2:0]              arsize,
   output logic [1:0]              arburst,
   output logic                    arvalid,
   input  logic                    arready,
   input  logic [DATA_WIDTH-1:0]   rdata,
   input  logic [1:0]              rresp,
   input  logic                    rlast,
   input  logic                    rvalid,
   output logic                    rready
);

   localparam int unsigned STRB_W = DATA_WIDTH / 8;
   localparam int unsigned SIZE   = $clog2(STRB_W);
   localparam int unsigned PAGE   = 4096;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_AW    = 3'd1;
   localparam logic [2:0] S_WDAT  = 3'd2;
   localparam logic [2:0] S_BRESP = 3'd3;
   localparam logic [2:0] S_AR    = 3'd4;
   localparam logic [2:0] S_RDAT  = 3'd5;
   localparam logic [2:0] S_DONE  = 3'd6;

   logic [2:0]            state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [7:0]            len_q;
   logic [7:0]            beat_q;
   logic [1:0]            resp_q;
   logic                  err_q;

   logic        cmd_fire;
   logic        w_fire;
   logic        r_fire;
   logic        b_fire;
   logic        beat_last;
   logic        page_err;
   logic [31:0] page_end;

   // Byte offset just past the burst, relative to the start of its 4KB page
   assign page_end  = (32'(cmd_addr) & 32'(PAGE - 1))
                    + (32'(cmd_len) + 32'd1) * 32'(STRB_W);
   assign page_err  = page_end > 32'(PAGE);

   assign cmd_fire  = cmd_valid && (state_q == S_IDLE);
   assign w_fire    = wvalid && wready;
   assign r_fire    = rd_valid && rd_ready;
   assign b_fire    = bvalid && (state_q == S_BRESP);
   assign beat_last = beat_q == len_q;

   assign cmd_ready  = state_q == S_IDLE;
   assign done_valid = state_q == S_DONE;
   assign done_resp  = resp_q;
   assign done_err   = err_q;

   assign awvalid = state_q == S_AW;
   assign awaddr  = addr_q;
   assign awlen   = len_q;
   assign awsize  = 3'(SIZE);
   assign awburst = 2'b01;

   assign arvalid = state_q == S_AR;
   assign araddr  = addr_q;
   assign arlen   = len_q;
   assign arsize  = 3'(SIZE);
   assign arburst = 2'b01;

   // W and R are pass-throughs, gated so nothing leaks outside the data phase
   assign wvalid   = (state_q == S_WDAT) && wr_valid;
   assign wr_ready = (state_q == S_WDAT) && wready;
   assign wdata    = wr_data;
   assign wstrb    = '1;
   assign wlast    = (state_q == S_WDAT) && beat_last;
   assign bready   = state_q == S_BRESP;

   assign rready   = (state_q == S_RDAT) && rd_ready;
   assign rd_valid = (state_q == S_RDAT) && rvalid;
   assign rd_data  = rdata;

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (cmd_fire) begin
               if (page_err)       state_d = S_DONE;
               else if (cmd_write) state_d = S_AW;
               else                state_d = S_AR;
            end
         end
         S_AW:    if (awready) state_d = S_WDAT;
         S_WDAT:  if (w_fire && beat_last) state_d = S_BRESP;
         S_BRESP: if (bvalid) state_d = S_DONE;
         S_AR:    if (arready) state_d = S_RDAT;
         S_RDAT:  if (r_fire && (beat_last || rlast)) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         len_q   <= '0;
         beat_q  <= '0;
         resp_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (cmd_fire) begin
            addr_q <= cmd_addr;
            len_q  <= cmd_len;
            beat_q <= '0;
            resp_q <= page_err ? 2'b10 : 2'b00;
            err_q  <= page_err;
         end
         if (w_fire) beat_q <= beat_q + 8'd1;
         if (b_fire) resp_q <= bresp;
         if (r_fire) begin
            beat_q <= beat_q + 8'd1;
            if (rresp > resp_q) resp_q <= rresp;
            // rlast must coincide exactly with the final counted beat
            if (rlast != beat_last) err_q <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_axi4_master_engine.sv
// Randomized bench for axi4_master_engine: an AXI slave with memory plus a
// word-level reference memory and per-command expected completion status.
module tb_axi4_master_engine;

   logic        clk, rst;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [15:0] cmd_addr;
   logic [7:0]  cmd_len;
   logic [31:0] wr_data, rd_data;
   logic        wr_valid, wr_ready, rd_valid, rd_ready;
   logic        done_valid, done_err;
   logic [1:0]  done_resp;
   logic [15:0] awaddr, araddr;
   logic [7:0]  awlen, arlen;
   logic [2:0]  awsize, arsize;
   logic [1:0]  awburst, arburst;
   logic        awvalid, awready, arvalid, arready;
   logic [31:0] wdata, rdata;
   logic [3:0]  wstrb;
   logic        wlast, wvalid, wready;
   logic [1:0]  bresp, rresp;
   logic        bvalid, bready, rlast, rvalid, rready;

   axi4_master_engine #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
      .done_valid(done_valid), .done_resp(done_resp), .done_err(done_err),
      .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
   );

   bit   [31:0] mem [0:16383];
   logic [31:0] ref_mem [int];
   logic [31:0] wbuf [0:255];
   logic [1:0]  rresp_tab [0:255];

   int n_cmp = 0;
   int n_bad = 0;
   int cyc_g = 0;

   bit          cfg_zero = 1'b1;
   int          cfg_aw_delay = 0, cfg_b_delay = 0, cfg_wmode = 0, cfg_rmode = 0, cfg_early = 0;
   logic [1:0]  cfg_bresp = 2'b00;
   logic [15:0] exp_addr = '0;
   logic [7:0]  exp_len = '0;
   int          b_cyc = 0;

   int aw_wait, wbase, wlen, wbeat, b_wait, rbase, rlen, rbeat;
   bit aw_done, b_pend, r_active, r_hold, wtog;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc_g <= cyc_g + 1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc_g);
      end
   endtask

   // AXI slave: drives on the falling edge, books handshakes just before the rising edge
   initial begin
      awready = 0; wready = 0; bvalid = 0; bresp = 0; arready = 0;
      rvalid = 0; rdata = 0; rresp = 0; rlast = 0;
      aw_wait = 0; wbase = 0; wlen = 0; wbeat = 0; b_wait = 0;
      rbase = 0; rlen = 0; rbeat = 0;
      aw_done = 0; b_pend = 0; r_active = 0; r_hold = 0; wtog = 0;
      forever begin
         @(negedge clk);
         wtog    = !wtog;
         awready = awvalid && (cfg_zero || aw_wait >= cfg_aw_delay);
         wready  = cfg_zero ? 1'b1 : (cfg_wmode == 1) ? wtog : 1'($urandom % 2);
         bvalid  = b_pend && (cfg_zero || b_wait >= cfg_b_delay);
         bresp   = cfg_bresp;
         arready = arvalid && (cfg_zero || ($urandom % 2) == 0);
         if (r_active && !r_hold && (cfg_zero || ($urandom % 4) != 0)) begin
            r_hold = 1'b1;
            rdata  = mem[(rbase + rbeat) % 16384];
            rresp  = rresp_tab[rbeat % 256];
            rlast  = (cfg_rmode == 2) ? 1'b0 :
                     ((rbeat == rlen) || (cfg_rmode == 1 && rbeat == cfg_early));
         end
         rvalid = r_hold;
         #1;
         if (rst) begin
            aw_wait = 0; wbeat = 0; b_wait = 0; rbeat = 0;
            aw_done = 0; b_pend = 0; r_active = 0; r_hold = 0;
         end else begin
            if (awvalid) begin
               chk("aw_addr", 64'(awaddr), 64'(exp_addr));
               chk("aw_len", 64'(awlen), 64'(exp_len));
            end
            if (awvalid && awready) begin
               chk("aw_size", 64'(awsize), 64'd2);
               chk("aw_burst", 64'(awburst), 64'd1);
               wbase = int'(awaddr) / 4; wlen = int'(awlen); wbeat = 0;
               aw_done = 1; aw_wait = 0;
            end else if (awvalid) aw_wait++;
            if (wvalid) chk("w_after_aw", 64'(aw_done), 64'd1);
            if (wvalid && wready) begin
               mem[(wbase + wbeat) % 16384] = wdata;
               chk("wlast", 64'(wlast), 64'(wbeat == wlen));
               chk("wstrb", 64'(wstrb), 64'hF);
               wbeat++;
               if (wbeat > wlen) begin b_pend = 1; b_wait = 0; aw_done = 0; end
            end
            if (bvalid && bready) begin b_pend = 0; b_cyc = cyc_g; end
            else if (b_pend) b_wait++;
            if (arvalid) begin
               chk("ar_addr", 64'(araddr), 64'(exp_addr));
               chk("ar_len", 64'(arlen), 64'(exp_len));
            end
            if (arvalid && arready) begin
               chk("ar_size", 64'(arsize), 64'd2);
               chk("ar_burst", 64'(arburst), 64'd1);
               rbase = int'(araddr) / 4; rlen = int'(arlen); rbeat = 0; r_active = 1;
            end
            if (rvalid && rready) begin
               r_hold = 0;
               if (rlast || rbeat == rlen) r_active = 0;
               rbeat++;
            end
         end
      end
   end

   // One command end-to-end; rst_beat >= 0 aborts with reset once that many user beats moved
   task automatic run_cmd(input bit wr, input logic [15:0] addr, input logic [7:0] len,
                          input int rdmode, input int rst_beat);
      int beat, cyc, done_cyc, last_cyc, exp_beats, last, w;
      bit done_seen, spanerr, exp_err;
      logic [1:0]  exp_resp;
      logic [31:0] exp_d;
      spanerr = (int'(addr & 16'h0FFF) + (int'(len) + 1) * 4) > 4096;
      if (spanerr) begin
         exp_resp = 2'b10; exp_err = 1; exp_beats = 0;
      end else if (wr) begin
         exp_resp = cfg_bresp; exp_err = 0; exp_beats = int'(len) + 1;
      end else begin
         last = int'(len);
         if (cfg_rmode == 1 && cfg_early < int'(len)) last = cfg_early;
         exp_beats = last + 1;
         exp_err = (cfg_rmode == 2) || (cfg_rmode == 1 && cfg_early < int'(len));
         exp_resp = 2'b00;
         for (int i = 0; i <= last; i++)
            if (rresp_tab[i] > exp_resp) exp_resp = rresp_tab[i];
      end
      exp_addr = addr; exp_len = len;
      @(negedge clk);
      cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_len = len;
      wr_valid = 0; rd_ready = 0;
      #1;
      chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);
      beat = 0; cyc = 0; done_seen = 0; done_cyc = 0; last_cyc = -10;
      while (!done_seen && cyc < 3000) begin
         @(negedge clk);
         cyc++;
         cmd_valid = 0;
         if (rst_beat >= 0 && beat == rst_beat) begin
            rst = 1;
            @(negedge clk);
            rst = 0; wr_valid = 1; rd_ready = 1;
            #1;
            chk("rst_awvalid", 64'(awvalid), 64'd0);
            chk("rst_wvalid", 64'(wvalid), 64'd0);
            chk("rst_wr_ready", 64'(wr_ready), 64'd0);
            chk("rst_bready", 64'(bready), 64'd0);
            chk("rst_rready", 64'(rready), 64'd0);
            chk("rst_done", 64'(done_valid), 64'd0);
            chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
            @(negedge clk);
            wr_valid = 0; rd_ready = 0;
            #1;
            chk("rst_no_done", 64'(done_valid), 64'd0);
            return;
         end
         wr_valid = wr && (beat <= int'(len)) && (cfg_zero || ($urandom % 4) != 0);
         wr_data  = wbuf[beat % 256];
         case (rdmode)
            0:       rd_ready = 1'b1;
            1:       rd_ready = 1'(cyc % 2);
            default: rd_ready = 1'($urandom % 2);
         endcase
         #1;
         if (cyc == 1 && !spanerr) chk("addr_latency", 64'(wr ? awvalid : arvalid), 64'd1);
         if (spanerr) chk("span_no_bus", 64'(awvalid || arvalid), 64'd0);
         if (rd_valid) chk("rready_track", 64'(rready), 64'(rd_ready));
         if (wr_valid && wr_ready) beat++;
         if (rd_valid && rd_ready) begin
            w = int'(addr) / 4 + beat;
            exp_d = ref_mem.exists(w) ? ref_mem[w] : 32'h0;
            chk("rd_data", 64'(rd_data), 64'(exp_d));
            beat++;
            last_cyc = cyc_g;
         end
         if (done_valid) begin done_seen = 1; done_cyc = cyc_g; end
      end
      if (!done_seen) begin
         chk("done_timeout", 64'd0, 64'd1);
      end else begin
         chk("done_resp", 64'(done_resp), 64'(exp_resp));
         chk("done_err", 64'(done_err), 64'(exp_err));
         chk("beats", 64'(beat), 64'(exp_beats));
         if (spanerr)  chk("span_latency", 64'(cyc <= 2), 64'd1);
         else if (wr)  chk("b_to_done", 64'(done_cyc), 64'(b_cyc + 1));
         else          chk("r_to_done", 64'(done_cyc), 64'(last_cyc + 1));
      end
      @(negedge clk);
      wr_valid = 0;
      #1;
      chk("done_pulse", 64'(done_valid), 64'd0);
      chk("back_idle", 64'(cmd_ready), 64'd1);
      if (wr && done_seen && !spanerr)
         for (int i = 0; i <= int'(len); i++) ref_mem[int'(addr) / 4 + i] = wbuf[i];
   endtask

   logic [15:0] ra;
   logic [7:0]  rl;
   int          rsel;

   initial begin
      rst = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0;
      wr_data = 0; wr_valid = 1; rd_ready = 1;
      for (int i = 0; i < 256; i++) begin wbuf[i] = 32'h0; rresp_tab[i] = 2'b00; end
      repeat (3) @(negedge clk);
      #1;
      chk("rst_awvalid0", 64'(awvalid), 64'd0);
      chk("rst_arvalid0", 64'(arvalid), 64'd0);
      chk("rst_wvalid0", 64'(wvalid), 64'd0);
      chk("rst_wr_ready0", 64'(wr_ready), 64'd0);
      chk("rst_bready0", 64'(bready), 64'd0);
      chk("rst_rready0", 64'(rready), 64'd0);
      chk("rst_rd_valid0", 64'(rd_valid), 64'd0);
      chk("rst_done0", 64'(done_valid), 64'd0);
      chk("rst_done_err0", 64'(done_err), 64'd0);
      chk("rst_done_resp0", 64'(done_resp), 64'd0);
      chk("rst_addr0", 64'({awaddr, araddr}), 64'd0);
      chk("rst_len0", 64'({awlen, arlen}), 64'd0);
      @(negedge clk);
      rst = 0; wr_valid = 0; rd_ready = 0;
      #1;
      chk("cmd_ready_after_rst", 64'(cmd_ready), 64'd1);

      // zero-wait write then toggling read-back
      for (int i = 0; i < 4; i++) wbuf[i] = 32'hA0 + 32'(i);
      run_cmd(1'b1, 16'h0100, 8'd3, 0, -1);
      run_cmd(1'b0, 16'h0100, 8'd3, 1, -1);

      // AW held off, W ready every other cycle
      cfg_zero = 0; cfg_aw_delay = 5; cfg_wmode = 1; cfg_b_delay = 1;
      for (int i = 0; i < 4; i++) wbuf[i] = 32'hB0 + 32'(i);
      run_cmd(1'b1, 16'h0200, 8'd3, 0, -1);
      cfg_zero = 1;
      run_cmd(1'b0, 16'h0200, 8'd3, 0, -1);

      // burst ending exactly on the page edge, then one crossing it
      for (int i = 0; i < 4; i++) wbuf[i] = 32'hC0 + 32'(i);
      run_cmd(1'b1, 16'h0FF0, 8'd3, 0, -1);
      run_cmd(1'b1, 16'h0FF8, 8'd3, 0, -1);

      // SLVERR on beat 0 with an early rlast
      rresp_tab[0] = 2'b10; cfg_rmode = 1; cfg_early = 0;
      run_cmd(1'b0, 16'h0100, 8'd1, 0, -1);
      rresp_tab[0] = 2'b00; cfg_rmode = 0;

      // reset mid-write, then the same write runs clean
      for (int i = 0; i < 8; i++) wbuf[i] = 32'hD0 + 32'(i);
      run_cmd(1'b1, 16'h0300, 8'd7, 0, 2);
      run_cmd(1'b1, 16'h0300, 8'd7, 0, -1);
      run_cmd(1'b0, 16'h0300, 8'd7, 2, -1);

      for (int it = 0; it < 24; it++) begin
         ra = 16'(32'h1000 + (($urandom % 32'h3000) << 2));
         if (($urandom % 5) == 0) ra = {ra[15:12], 12'hFF0};
         rl = 8'($urandom % 16);
         cfg_zero = ($urandom % 3) == 0;
         cfg_wmode = int'($urandom % 2);
         cfg_aw_delay = int'($urandom % 4);
         cfg_b_delay = int'($urandom % 3);
         cfg_bresp = 2'($urandom % 4);
         for (int i = 0; i < 256; i++) wbuf[i] = $urandom;
         run_cmd(1'b1, ra, rl, 2, -1);
         for (int i = 0; i < 256; i++)
            rresp_tab[i] = (($urandom % 4) == 0) ? 2'($urandom % 4) : 2'b00;
         rsel = int'($urandom % 6);
         cfg_rmode = (rsel < 4) ? 0 : (rsel == 4) ? 1 : 2;
         cfg_early = int'($urandom % (32'(rl) + 32'd1));
         run_cmd(1'b0, ra, rl, 2, -1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
